// File: rtl/sprite_anim_mux.sv
// Sprite source selector and animation sequencer: latches anim_state on frame_tick, muxes one sprite-ROM channel.
// Latency: 1 cycle from src_pix/pix_valid_in to pix_out/pix_valid_out/opaque; src_sel/mirror/frame_idx update the cycle after frame_tick.
// Backpressure: none; accepts a pixel every cycle and never stalls.
module sprite_anim_mux #(
  parameter int PIX_W       = 4,
  parameter int NUM_SRC     = 4,
  parameter int STATE_W     = 4,
  parameter int FRAMES      = 4,
  parameter int TICK_DIV    = 6,
  parameter int TRANSPARENT = 0,
  localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int FRM_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_tick,
  input  logic [STATE_W-1:0]       anim_state,
  input  logic [NUM_SRC*PIX_W-1:0] src_pix,
  input  logic                     pix_valid_in,
  output logic [PIX_W-1:0]         pix_out,
  output logic                     pix_valid_out,
  output logic                     opaque,
  output logic [SEL_W-1:0]         src_sel,
  output logic [FRM_W-1:0]         frame_idx,
  output logic                     mirror
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ACT_W = STATE_W - 1;

  localparam logic [PIX_W-1:0] TRANS_PIX = PIX_W'(TRANSPARENT);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(FRAMES - 1);

  logic [STATE_W-1:0] active_state;
  logic [DIV_W-1:0]   div_cnt;
  logic [ACT_W-1:0]   new_action;
  logic [ACT_W-1:0]   cur_action;
  logic               new_in_range;
  logic [PIX_W-1:0]   sel_pix;

  assign new_action   = anim_state[STATE_W-1:1];
  assign cur_action   = active_state[STATE_W-1:1];
  assign new_in_range = (32'(new_action) < NUM_SRC);

  // Facing bit lives directly in the latched state register, so it is already registered.
  assign mirror = active_state[0];

  // Latch the requested state on each frame tick and step the animation counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_state <= '0;
      src_sel      <= '0;
      div_cnt      <= '0;
      frame_idx    <= '0;
    end else if (frame_tick) begin
      active_state <= anim_state;
      src_sel      <= new_in_range ? SEL_W'(new_action) : '0;
      if ((new_action != cur_action) || (new_action == '0)) begin
        // A new action restarts its cycle; idle never animates.
        div_cnt   <= '0;
        frame_idx <= '0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt   <= '0;
        frame_idx <= (frame_idx == FRM_LAST) ? '0 : frame_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Pick the channel addressed by the current (pre-tick) src_sel register.
  always_comb begin
    sel_pix = src_pix[PIX_W-1:0];
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel == SEL_W'(k)) begin
        sel_pix = src_pix[k*PIX_W +: PIX_W];
      end
    end
  end

  // Register the selected pixel; invalid cycles present the transparent index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_out       <= TRANS_PIX;
      pix_valid_out <= 1'b0;
      opaque        <= 1'b0;
    end else begin
      pix_out       <= pix_valid_in ? sel_pix : TRANS_PIX;
      pix_valid_out <= pix_valid_in;
      opaque        <= pix_valid_in && (sel_pix != TRANS_PIX);
    end
  end

endmodule

// File: tb/tb_sprite_anim_mux.sv
module tb_sprite_anim_mux;

  localparam int PIX_W    = 4;
  localparam int NUM_SRC  = 4;
  localparam int FRAMES   = 4;
  localparam int TICK_DIV = 6;
  localparam int TRANSP   = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic [3:0]  anim_state;
  logic [15:0] src_pix;
  logic        pix_valid_in;
  logic [3:0]  pix_out;
  logic        pix_valid_out;
  logic        opaque;
  logic [1:0]  src_sel;
  logic [1:0]  frame_idx;
  logic        mirror;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // reference model: action/facing latched at ticks, number of counted ticks in current action
  int m_action = 0;
  int m_facing = 0;
  int m_ticks  = 0;
  int e_pix    = TRANSP;
  int e_pv     = 0;
  int e_opq    = 0;

  sprite_anim_mux dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .anim_state   (anim_state),
    .src_pix      (src_pix),
    .pix_valid_in (pix_valid_in),
    .pix_out      (pix_out),
    .pix_valid_out(pix_valid_out),
    .opaque       (opaque),
    .src_sel      (src_sel),
    .frame_idx    (frame_idx),
    .mirror       (mirror)
  );

  always #5 clk = ~clk;

  function automatic int exp_sel();
    return (m_action < NUM_SRC) ? m_action : 0;
  endfunction

  function automatic int exp_frame();
    return (m_ticks / TICK_DIV) % FRAMES;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string ctx);
    chk({ctx, ".pix_out"},       32'(pix_out),       32'(e_pix));
    chk({ctx, ".pix_valid_out"}, 32'(pix_valid_out), 32'(e_pv));
    chk({ctx, ".opaque"},        32'(opaque),        32'(e_opq));
    chk({ctx, ".src_sel"},       32'(src_sel),       32'(exp_sel()));
    chk({ctx, ".frame_idx"},     32'(frame_idx),     32'(exp_frame()));
    chk({ctx, ".mirror"},        32'(mirror),        32'(m_facing));
  endtask

  task automatic model_reset();
    m_action = 0; m_facing = 0; m_ticks = 0;
    e_pix = TRANSP; e_pv = 0; e_opq = 0;
  endtask

  // one cycle: drive at negedge, model the edge, check at the next negedge
  task automatic step(input string ctx, input bit tk, input int st, input bit pv, input logic [15:0] px);
    int ch;
    int na;
    frame_tick   = tk;
    anim_state   = 4'(st);
    pix_valid_in = pv;
    src_pix      = px;
    ch    = int'((px >> (exp_sel() * PIX_W)) & 16'hF);
    e_pv  = pv ? 1 : 0;
    e_pix = pv ? ch : TRANSP;
    e_opq = (pv && ch != TRANSP) ? 1 : 0;
    if (tk) begin
      na = st / 2;
      if (na != m_action) m_ticks = 0;
      else if (na != 0)   m_ticks++;
      m_action = na;
      m_facing = st % 2;
    end
    @(negedge clk);
    chk_all(ctx);
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; anim_state = '0; src_pix = '0; pix_valid_in = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // latch only on tick
    step("no_tick", 0, 5, 0, 16'h0);
    chk("no_tick.src_sel0", 32'(src_sel), 32'd0);
    step("tick5", 1, 5, 0, 16'h0);
    chk("tick5.src_sel2", 32'(src_sel), 32'd2);
    chk("tick5.mirror1",  32'(mirror),  32'd1);
    for (int i = 0; i < 3 * TICK_DIV; i++) step("adv5", 1, 5, 1, 16'h1234);
    chk("adv5.frame3", 32'(frame_idx), 32'd3);

    // asynchronous reset between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk);
    reset_n = 1'b1;

    // cadence in state 2 with idle cycles between ticks
    step("lat2", 1, 2, 0, 16'h0);
    for (int i = 0; i < 24; i++) begin
      step("cad2", 1, 2, 0, 16'h0);
      step("cad2_gap", 0, 7, 1, 16'h5555);
    end
    for (int i = 0; i < 24; i++) step("idle", 1, 0, 0, 16'h0);
    chk("idle.frame0", 32'(frame_idx), 32'd0);

    // facing-only change keeps the counters
    step("lat2b", 1, 2, 0, 16'h0);
    for (int i = 0; i < 8; i++) step("run2", 1, 2, 0, 16'h0);
    for (int i = 0; i < 4; i++) step("face3", 1, 3, 0, 16'h0);
    chk("face3.frame2", 32'(frame_idx), 32'd2);
    // action change restarts the cycle
    step("act4", 1, 4, 0, 16'h0);
    chk("act4.frame0", 32'(frame_idx), 32'd0);

    // out-of-range action selects channel 0
    step("oor12", 1, 12, 0, 16'h0);
    chk("oor12.src_sel0", 32'(src_sel), 32'd0);

    // pixel mux
    step("lat7", 1, 7, 0, 16'h0);
    step("mux3", 0, 7, 1, 16'hDCB0);
    chk("mux3.pix_D", 32'(pix_out), 32'hD);
    step("lat0", 1, 0, 1, 16'hDCB0);
    step("mux0", 0, 0, 1, 16'hDCB0);
    chk("mux0.opaque0", 32'(opaque), 32'd0);
    step("novld", 0, 0, 0, 16'hDCB0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int st;
      st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'(anim_state);
      step("rnd", ($urandom_range(0, 2) == 0), st, ($urandom_range(0, 3) != 0), 16'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sprite_anim_mux.md
# sprite_anim_mux

Parametrised sprite source selector and animation sequencer for the character renderer. Takes the character's animation state, latches it on frame boundaries, and picks one of NUM_SRC sprite-ROM pixel channels. It advances an animation frame index at a programmable frame rate and drives a mirror flag for left/right facing. It sits between the character state machine and the pixel compositor, and outputs registered palette indices with an opacity flag.

## Interface
- PIX_W, 4, palette index width per pixel
- NUM_SRC, 4, number of sprite-ROM pixel channels (one per action)
- STATE_W, 4, animation state width; bit 0 = facing, upper bits = action
- FRAMES, 4, frames per animation cycle (≥1)
- TICK_DIV, 6, frame_ticks per animation frame (≥1)
- TRANSPARENT, 0, palette index treated as transparent

- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- anim_state  in  STATE_W  requested animation state
- src_pix  in  NUM_SRC*PIX_W  channel k occupies bits [k*PIX_W +: PIX_W]
- pix_valid_in  in  1  src_pix is valid this cycle
- pix_out  out  PIX_W  selected palette index (registered)
- pix_valid_out  out  1  pix_valid_in delayed by one cycle
- opaque  out  1  pix_valid_out and pix_out ≠ TRANSPARENT
- src_sel  out  max(1,clog2(NUM_SRC))  active channel index
- frame_idx  out  max(1,clog2(FRAMES))  animation frame to the ROM address generator
- mirror  out  1  1 = facing left; horizontal flip for the address generator

## Operation
- Reset (Reset_n=0, asynchronous): active_state=0, div_cnt=0, frame_idx=0, src_sel=0, mirror=0, pix_out=TRANSPARENT, pix_valid_out=0, opaque=0.
- State latch: anim_state is sampled only on cycles with frame_tick=1, into active_state. Changes between ticks have no effect. This prevents a mid-scan sprite change.
- Decode of the active_state register:
  - action = active_state[STATE_W-1:1]
  - mirror = active_state[0]
  - src_sel = action if action < NUM_SRC, else 0.
- Animation sequencer, on frame_tick:
  - New action ≠ current action: div_cnt←0, frame_idx←0.
  - Same action, facing change only: counters continue; only mirror updates.
  - Action 0 (idle): frame_idx held at 0; div_cnt held at 0.
  - Otherwise: div_cnt increments. When div_cnt==TICK_DIV-1, div_cnt←0 and frame_idx←(frame_idx+1) mod FRAMES.
  - If TICK_DIV=1, frame_idx advances on every tick.
  - If FRAMES=1, frame_idx stays 0.
- Pixel path, every cycle:
  - pix_out ← pix_valid_in ? src_pix channel[src_sel] : TRANSPARENT
  - pix_valid_out ← pix_valid_in
  - opaque ← pix_valid_in && selected pixel ≠ TRANSPARENT
- Simultaneous frame_tick and pix_valid_in: the pixel uses the src_sel register value before the update.

## Timing
- All outputs are registered.
- src_sel, mirror and frame_idx change in the cycle after the frame_tick cycle.
- Pixel latency is 1 cycle from pix_valid_in/src_pix to pix_out/pix_valid_out/opaque. Full throughput, no stalls.
- frame_tick pulses closer than 1 cycle apart do not occur. Back-to-back ticks are each counted.
- Reset assertion mid-frame clears all state immediately. After release, the first frame_tick latches anim_state.

## Test plan
- Reset mid-operation: with src_sel=2, frame_idx=3, drive Reset_n=0 → all outputs 0 within the same cycle, without a clock edge; pix_out=TRANSPARENT.
- State latch: anim_state=5 with no tick → src_sel=0, mirror=0. Pulse frame_tick → next cycle src_sel=2, mirror=1, frame_idx=0.
- Frame cadence: anim_state=2 held for 24 ticks → frame_idx becomes 1, 2, 3, 0 after ticks 6, 12, 18, 24. Sequence anim_state=0 for 24 ticks → frame_idx stays 0.
- Facing vs action change:
  - After 8 ticks in state 2 (frame_idx=1), switch to state 3 → frame_idx stays 1 and advances to 2 at tick 12.
  - Switch to state 4 instead → frame_idx=0, div_cnt=0.
- Out-of-range action: anim_state=12 (action 6) with NUM_SRC=4 → src_sel=0 after the tick.
- Pixel mux: src_pix={4'hD,4'hC,4'hB,4'h0}, pix_valid_in=1.
  - src_sel=3 → next cycle pix_out=D, opaque=1.
  - src_sel=0 → pix_out=0, opaque=0.
  - pix_valid_in=0 → pix_out=0, pix_valid_out=0.
